cordic_phase_estimator: RTL and testbench

Inverse companion to polynomial_approximation: that block maps a 16-bit phase to a sine sample, and this one recovers phase and magnitude from an (I, Q) sample pair. It uses an iterative vectoring-mode CORDIC, one micro-rotation per clock, behind valid/ready handshakes. The phase format is shared with the sine block: unsigned 16-bit, 65536 = 2π, π = 32768, π/2 = 16384. Typical placement is after the qubit drive/readout mixer, to extract the tone phase for movement feedback.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_vector_step.sv | 29 ++
 rtl/cordic_phase_estimator.sv | 143 ++++++++++++++
 tb/tb_cordic_phase_estimator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the vectoring-mode CORDIC phase estimator.
// Phase units: 65536 = 2*pi, so the arctangent table is in the same unsigned 16-bit format.
package cordic_pkg;

  localparam logic [15:0] ATAN_TABLE [16] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
  };

  localparam logic [15:0] PHASE_PI      = 16'd32768;
  localparam logic [15:0] PHASE_HALF_PI = 16'd16384;

  // 2^15 / 1.64676, the reciprocal of the accumulated CORDIC gain
  localparam int unsigned MAG_COMP_K = 19898;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    COMP,
    DONE
  } state_t;

endpackage

// File: rtl/cordic_vector_step.sv
// One combinational vectoring micro-rotation: drives y toward zero, accumulating the angle in z.
// Both x and y updates use the incoming (old) x and y; z wraps modulo 2^16.
module cordic_vector_step
  import cordic_pkg::*;
#(
  parameter int INT_W = 18
) (
  input  logic signed [INT_W-1:0] x,
  input  logic signed [INT_W-1:0] y,
  input  logic        [15:0]      z,
  input  logic        [3:0]       k,
  output logic signed [INT_W-1:0] x_next,
  output logic signed [INT_W-1:0] y_next,
  output logic        [15:0]      z_next
);

  logic signed [INT_W-1:0] x_sh;
  logic signed [INT_W-1:0] y_sh;
  logic                    y_neg;

  assign x_sh  = x >>> k;
  assign y_sh  = y >>> k;
  assign y_neg = y[INT_W-1];

  assign x_next = y_neg ? (x - y_sh) : (x + y_sh);
  assign y_next = y_neg ? (y + x_sh) : (y - x_sh);
  assign z_next = y_neg ? (z - ATAN_TABLE[k]) : (z + ATAN_TABLE[k]);

endmodule

// File: rtl/cordic_phase_estimator.sv
// Iterative vectoring CORDIC: (I, Q) -> 16-bit phase and magnitude, one micro-rotation per clock.
// Define CORDIC_MAG_COMP_EN to add a COMP state that removes the CORDIC gain from out_mag.
module cordic_phase_estimator
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 14,
  parameter int DATA_W     = 16,
  parameter int INT_W      = 18
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_phase,
  output logic [DATA_W:0]   out_mag
);

  generate
    if (ITERATIONS < 1 || ITERATIONS > 16) begin : g_bad_iterations
      $error("cordic_phase_estimator: ITERATIONS must be in 1..16");
    end
    if (INT_W < DATA_W + 2) begin : g_bad_int_w
      $error("cordic_phase_estimator: INT_W must be at least DATA_W+2");
    end
  endgenerate

  state_t state_q, state_d;

  logic signed [INT_W-1:0] x_q, y_q;
  logic        [15:0]      z_q;
  logic        [3:0]       cnt_q;
  logic                    zero_q;
  logic        [15:0]      phase_q;
  logic        [DATA_W:0]  mag_q;

  logic signed [INT_W-1:0] x_nx, y_nx;
  logic        [15:0]      z_nx;
  logic signed [INT_W-1:0] i_ext, q_ext;
  logic                    last_step;

  // Widen before negating so that -(-2^(DATA_W-1)) is representable
  assign i_ext = {{(INT_W-DATA_W){in_i[DATA_W-1]}}, in_i};
  assign q_ext = {{(INT_W-DATA_W){in_q[DATA_W-1]}}, in_q};

  assign last_step = (cnt_q == 4'(ITERATIONS - 1));

  cordic_vector_step #(
    .INT_W (INT_W)
  ) u_step (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .k      (cnt_q),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

`ifdef CORDIC_MAG_COMP_EN
  logic [INT_W+14:0] mag_prod;
  assign mag_prod = (INT_W+15)'(x_q) * (INT_W+15)'(MAG_COMP_K);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (in_valid) state_d = ROTATE;
`ifdef CORDIC_MAG_COMP_EN
      ROTATE: if (last_step) state_d = COMP;
`else
      ROTATE: if (last_step) state_d = DONE;
`endif
      COMP:   state_d = DONE;
      DONE:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      phase_q <= '0;
      mag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Left half-plane is folded by pi so the rotation only has to cover +-pi/2
            if (in_i[DATA_W-1]) begin
              x_q <= -i_ext;
              y_q <= -q_ext;
              z_q <= PHASE_PI;
            end else begin
              x_q <= i_ext;
              y_q <= q_ext;
              z_q <= '0;
            end
            cnt_q  <= '0;
            zero_q <= (in_i == '0) && (in_q == '0);
          end
        end
        ROTATE: begin
          x_q   <= x_nx;
          y_q   <= y_nx;
          z_q   <= z_nx;
          cnt_q <= cnt_q + 4'd1;
`ifndef CORDIC_MAG_COMP_EN
          if (last_step) begin
            phase_q <= zero_q ? '0 : z_nx;
            mag_q   <= zero_q ? '0 : x_nx[DATA_W:0];
          end
`endif
        end
        COMP: begin
`ifdef CORDIC_MAG_COMP_EN
          phase_q <= zero_q ? '0 : z_q;
          mag_q   <= zero_q ? '0 : mag_prod[15 +: DATA_W+1];
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_phase = phase_q;
  assign out_mag   = mag_q;

endmodule

// File: tb/tb_cordic_phase_estimator.sv
// Directed self-checking bench for cordic_phase_estimator (raw or gain-compensated build).
module tb_cordic_phase_estimator;

`ifdef CORDIC_MAG_COMP_EN
  localparam int LAT     = 15;
  localparam int MAG_AX  = 16384;
  localparam int MAG_DG  = 46341;
`else
  localparam int LAT     = 14;
  localparam int MAG_AX  = 26982;
  localparam int MAG_DG  = 76312;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_i;
  logic [15:0] in_q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_phase;
  logic [16:0] out_mag;

  int checks   = 0;
  int failures = 0;

  cordic_phase_estimator #(
    .ITERATIONS (14),
    .DATA_W     (16),
    .INT_W      (18)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_i      (in_i),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_phase (out_phase),
    .out_mag   (out_mag)
  );

  always #5 clock = ~clock;

  function automatic int pdist(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d = a - b;
    return d[15] ? (65536 - int'(d)) : int'(d);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Drives one sample through a full transfer; lat = -1 if any bounded wait expires
  task automatic run_sample(input int i, input int q, output logic [15:0] ph,
                            output logic [16:0] mg, output int lat);
    lat = -1;
    ph  = '0;
    mg  = '0;
    for (int n = 0; n < 50 && !in_ready; n++) begin
      @(posedge clock); #1;
    end
    if (!in_ready) return;
    in_i = i[15:0];
    in_q = q[15:0];
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    ph = out_phase;
    mg = out_mag;
    if (lat > 0) begin
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_i      = '0;
    in_q      = '0;
    #23;
    checks += 4;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (out_phase !== 16'd0) begin failures++; $display("FAIL reset_out_phase got=%0d want=0", out_phase); end
    if (out_mag !== 17'd0) begin failures++; $display("FAIL reset_out_mag got=%0d want=0", out_mag); end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_quadrants();
    int          vi [5] = '{16384, 0, -16384, 0, -32768};
    int          vq [5] = '{0, 16384, 0, -16384, -32768};
    logic [15:0] ep [5] = '{16'd0, 16'd16384, 16'd32768, 16'd49152, 16'd40960};
    logic [15:0] ph;
    logic [16:0] mg;
    int          lat;
    for (int t = 0; t < 5; t++) begin
      run_sample(vi[t], vq[t], ph, mg, lat);
      checks += 2;
      if (lat !== LAT) begin
        failures++;
        $display("FAIL quad%0d_latency got=%0d want=%0d", t, lat, LAT);
      end
      if (pdist(ph, ep[t]) > 3) begin
        failures++;
        $display("FAIL quad%0d_phase got=%0d want=%0d+-3", t, ph, ep[t]);
      end
      if (t == 0) begin
        checks++;
        if (iabs(int'(mg) - MAG_AX) > 8) begin
          failures++;
          $display("FAIL quad0_mag got=%0d want=%0d+-8", mg, MAG_AX);
        end
      end
      if (t == 4) begin
        checks++;
        if (iabs(int'(mg) - MAG_DG) > MAG_DG / 100) begin
          failures++;
          $display("FAIL quad4_mag got=%0d want=%0d+-1pct", mg, MAG_DG);
        end
      end
    end
  endtask

  task automatic test_zero();
    logic [15:0] ph;
    logic [16:0] mg;
    int          lat;
    run_sample(0, 0, ph, mg, lat);
    checks += 3;
    if (lat !== LAT) begin failures++; $display("FAIL zero_latency got=%0d want=%0d", lat, LAT); end
    if (ph !== 16'd0) begin failures++; $display("FAIL zero_phase got=%0d want=0", ph); end
    if (mg !== 17'd0) begin failures++; $display("FAIL zero_mag got=%0d want=0", mg); end
  endtask

  task automatic test_round_trip();
    logic [15:0] ph;
    logic [16:0] mg;
    int          lat;
    real         a, rc, rs;
    int          ci, si;
    for (int k = 0; k < 16; k++) begin
      a  = 2.0 * 3.14159265358979 * real'(k * 4096) / 65536.0;
      rc = 30000.0 * $cos(a);
      rs = 30000.0 * $sin(a);
      ci = $rtoi(rc + ((rc >= 0.0) ? 0.5 : -0.5));
      si = $rtoi(rs + ((rs >= 0.0) ? 0.5 : -0.5));
      run_sample(ci, si, ph, mg, lat);
      checks++;
      if (lat < 0 || pdist(ph, 16'(k * 4096)) > 4) begin
        failures++;
        $display("FAIL round_trip_%0d phase got=%0d want=%0d+-4 lat=%0d", k, ph, k * 4096, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ph0;
    logic [16:0] mg0;
    int          lat;
    lat = -1;
    in_i = 16'd16384;
    in_q = 16'd0;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (out_valid) begin lat = n; break; end
    end
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", lat, LAT); end
    ph0 = out_phase;
    mg0 = out_mag;
    in_i = 16'd0;
    in_q = 16'd16384;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      checks += 4;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid c=%0d got=%b want=1", c, out_valid); end
      if (out_phase !== ph0) begin failures++; $display("FAIL bp_hold_phase c=%0d got=%0d want=%0d", c, out_phase, ph0); end
      if (out_mag !== mg0) begin failures++; $display("FAIL bp_hold_mag c=%0d got=%0d want=%0d", c, out_mag, mg0); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); end
    end
    in_valid = 1'b0;
    checks++;
    if (pdist(ph0, 16'd0) > 3) begin failures++; $display("FAIL bp_phase got=%0d want=0+-3", ph0); end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    repeat (3) begin @(posedge clock); #1; end
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_ignored_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ignored_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ph;
    logic [16:0] mg;
    int          lat;
    in_i = 16'd16384;
    in_q = 16'd16384;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (6) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    if (out_phase !== 16'd0) begin failures++; $display("FAIL midrst_phase got=%0d want=0", out_phase); end
    if (out_mag !== 17'd0) begin failures++; $display("FAIL midrst_mag got=%0d want=0", out_mag); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale c=%0d got=%b want=0", c, out_valid); end
    end
    run_sample(0, 16384, ph, mg, lat);
    checks += 3;
    if (lat !== LAT) begin failures++; $display("FAIL midrst_next_latency got=%0d want=%0d", lat, LAT); end
    if (pdist(ph, 16'd16384) > 3) begin failures++; $display("FAIL midrst_next_phase got=%0d want=16384+-3", ph); end
    if (iabs(int'(mg) - MAG_AX) > 8) begin failures++; $display("FAIL midrst_next_mag got=%0d want=%0d+-8", mg, MAG_AX); end
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_zero();
    test_round_trip();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
